// File: rtl/median_sched_pkg.sv
// rtl/median_sched_pkg.sv - shared types and constants for the median frame sequencer
package median_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY_RD,
        S_COPY_WR,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    localparam int WIN_N     = 9;
    localparam int CORE_WAIT = 43;

endpackage

// File: rtl/MEDIAN.sv
// rtl/MEDIAN.sv - 9-pixel median core: loads a window while DSI is high, presents
// the median with DSO in the 42nd idle cycle after the window.
module MEDIAN #(
    parameter int SIZE = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            DSI,
    input  logic [SIZE-1:0] DI,
    output logic            DSO,
    output logic [SIZE-1:0] DO
);
    localparam logic [5:0] LAT_LAST = 6'd41;

    logic [SIZE-1:0] win_q [9];
    logic            armed_q;
    logic [5:0]      cnt_q;
    logic [3:0]      lt;
    logic [3:0]      le;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else if (DSI) begin
            for (int i = 0; i < 8; i++) win_q[i] <= win_q[i+1];
            win_q[8] <= DI;
            armed_q  <= 1'b1;
            cnt_q    <= '0;
        end else if (armed_q) begin
            armed_q <= (cnt_q != LAT_LAST);
            cnt_q   <= cnt_q + 6'd1;
        end
    end

    assign DSO = armed_q && !DSI && (cnt_q == LAT_LAST);

    // The median is the element with at most 4 smaller and at least 5 not-larger.
    always_comb begin
        DO = '0;
        lt = '0;
        le = '0;
        for (int i = 0; i < 9; i++) begin
            lt = '0;
            le = '0;
            for (int j = 0; j < 9; j++) begin
                if (win_q[j] <  win_q[i]) lt = lt + 4'd1;
                if (win_q[j] <= win_q[i]) le = le + 4'd1;
            end
            if (lt <= 4'd4 && le >= 4'd5) DO = win_q[i];
        end
    end

endmodule

// File: rtl/median_frame_sched.sv
// rtl/median_frame_sched.sv - walks a WxH frame, copies border pixels and writes
// the 3x3 median of every interior pixel.
module median_frame_sched
    import median_sched_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int W    = 16,
    parameter int H    = 16,
    parameter int AW   = $clog2(W*H)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            START,
    output logic            BUSY,
    output logic            DONE,
    output logic            RD_EN,
    output logic [AW-1:0]   RD_ADDR,
    input  logic [SIZE-1:0] RD_DATA,
    output logic            WR_EN,
    output logic [AW-1:0]   WR_ADDR,
    output logic [SIZE-1:0] WR_DATA
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);
    localparam logic [3:0]    K_LAST = 4'(WIN_N - 1);

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [3:0]      k_q, k_d;
    logic [SIZE-1:0] wdata_q, wdata_d;
    logic            dsi_q;
    logic            dso;
    logic [SIZE-1:0] med_do;
    logic            advance;
    logic [AW-1:0]   row, col, addr;

    MEDIAN #(.SIZE(SIZE)) u_median (
        .CLK  (CLK),
        .nRST (nRST),
        .DSI  (dsi_q),
        .DI   (RD_DATA),
        .DSO  (dso),
        .DO   (med_do)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            wdata_q <= '0;
            dsi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            wdata_q <= wdata_d;
            dsi_q   <= (state_q == S_FETCH);
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        wdata_d = wdata_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE:    if (START) state_d = S_COPY_RD;
            S_COPY_RD: state_d = S_COPY_WR;
            S_COPY_WR: advance = 1'b1;
            S_FETCH: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (dso) begin
                    wdata_d = med_do;
                    state_d = S_WRITE;
                end
            end
            S_WRITE:   advance = 1'b1;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (advance) begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
                x_d     = '0;
                y_d     = '0;
                state_d = S_DONE;
            end else begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
                state_d = (x_d == '0 || x_d == X_LAST || y_d == '0 || y_d == Y_LAST)
                          ? S_COPY_RD : S_FETCH;
            end
        end
    end

    // Window reads offset the current pixel by (k%3-1, k/3-1); only interior pixels fetch.
    always_comb begin
        row = AW'(y_q);
        col = AW'(x_q);
        if (state_q == S_FETCH) begin
            row = AW'(y_q) + AW'(k_q / 4'd3) - AW'(1);
            col = AW'(x_q) + AW'(k_q % 4'd3) - AW'(1);
        end
        addr = row * AW'(W) + col;
    end

    always_comb begin
        BUSY    = (state_q != S_IDLE);
        DONE    = (state_q == S_DONE);
        RD_EN   = (state_q == S_COPY_RD) || (state_q == S_FETCH);
        WR_EN   = (state_q == S_COPY_WR) || (state_q == S_WRITE);
        RD_ADDR = RD_EN ? addr : '0;
        WR_ADDR = WR_EN ? addr : '0;
        WR_DATA = (state_q == S_COPY_WR) ? RD_DATA :
                  (state_q == S_WRITE)   ? wdata_q : '0;
    end

endmodule

// File: tb/tb_median_frame_sched.sv
// tb/tb_median_frame_sched.sv - scoreboard bench for median_frame_sched on 3x3 and 4x4 frames
module tb_median_frame_sched;
    import median_sched_pkg::*;

    typedef struct { int addr; int data; } wr_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- DUT A: 3x3 ----------------
    logic       nrst_a, start_a, busy_a, done_a, rd_en_a, wr_en_a;
    logic [3:0] rd_addr_a, wr_addr_a;
    logic [7:0] rd_data_a, wr_data_a;
    int         src_a [16];

    median_frame_sched #(.SIZE(8), .W(3), .H(3)) dut_a (
        .CLK(CLK), .nRST(nrst_a), .START(start_a), .BUSY(busy_a), .DONE(done_a),
        .RD_EN(rd_en_a), .RD_ADDR(rd_addr_a), .RD_DATA(rd_data_a),
        .WR_EN(wr_en_a), .WR_ADDR(wr_addr_a), .WR_DATA(wr_data_a)
    );

    // ---------------- DUT B: 4x4 ----------------
    logic       nrst_b, start_b, busy_b, done_b, rd_en_b, wr_en_b;
    logic [3:0] rd_addr_b, wr_addr_b;
    logic [7:0] rd_data_b, wr_data_b;
    int         src_b [16];

    median_frame_sched #(.SIZE(8), .W(4), .H(4)) dut_b (
        .CLK(CLK), .nRST(nrst_b), .START(start_b), .BUSY(busy_b), .DONE(done_b),
        .RD_EN(rd_en_b), .RD_ADDR(rd_addr_b), .RD_DATA(rd_data_b),
        .WR_EN(wr_en_b), .WR_ADDR(wr_addr_b), .WR_DATA(wr_data_b)
    );

    // Source memories with one cycle of read latency
    always @(posedge CLK) rd_data_a <= 8'(src_a[rd_addr_a]);
    always @(posedge CLK) rd_data_b <= 8'(src_b[rd_addr_b]);

    // Reference model
    function automatic int exp_pix(input int s[16], input int w, input int h,
                                   input int x, input int y);
        int v [9];
        int t;
        if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return s[y*w + x];
        for (int k = 0; k < 9; k++) v[k] = s[(y - 1 + k / 3) * w + (x - 1 + k % 3)];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return v[4];
    endfunction

    function automatic int frame_cycles(input int w, input int h);
        int inner;
        inner = (w - 2) * (h - 2);
        return 2 * (w * h - inner) + (WIN_N + CORE_WAIT + 1) * inner + 1;
    endfunction

    wr_t exp_a [$];
    wr_t exp_b [$];
    wr_t ea, eb;

    int busy_cyc_a, done_cnt_a, wr_cnt_a;
    int wcount_a [16];
    int dst_a [16];
    int busy_cyc_b, done_cnt_b, wr_cnt_b;
    int wcount_b [16];
    int dst_b [16];
    logic rd_log [512];
    int   rd_alog [512];
    logic wr_log [512];
    int   wr_alog [512];

    always @(negedge CLK) begin
        if (busy_a) busy_cyc_a++;
        if (done_a) done_cnt_a++;
        if (rd_en_a && wr_en_a) check("a_rd_wr_overlap", 1, 0);
        if (wr_en_a) begin
            wr_cnt_a++;
            wcount_a[wr_addr_a]++;
            dst_a[wr_addr_a] = int'(wr_data_a);
            if (exp_a.size() == 0) check("a_unexpected_write", int'(wr_addr_a), -1);
            else begin
                ea = exp_a.pop_front();
                check("a_wr_addr", int'(wr_addr_a), ea.addr);
                check("a_wr_data", int'(wr_data_a), ea.data);
            end
        end
    end

    always @(negedge CLK) begin
        if (busy_b) begin
            busy_cyc_b++;
            if (busy_cyc_b < 512) begin
                rd_log[busy_cyc_b]  = rd_en_b;
                rd_alog[busy_cyc_b] = int'(rd_addr_b);
                wr_log[busy_cyc_b]  = wr_en_b;
                wr_alog[busy_cyc_b] = int'(wr_addr_b);
            end
        end
        if (done_b) done_cnt_b++;
        if (rd_en_b && wr_en_b) check("b_rd_wr_overlap", 1, 0);
        if (wr_en_b) begin
            wr_cnt_b++;
            wcount_b[wr_addr_b]++;
            dst_b[wr_addr_b] = int'(wr_data_b);
            if (exp_b.size() == 0) check("b_unexpected_write", int'(wr_addr_b), -1);
            else begin
                eb = exp_b.pop_front();
                check("b_wr_addr", int'(wr_addr_b), eb.addr);
                check("b_wr_data", int'(wr_data_b), eb.data);
            end
        end
    end

    task automatic prep_a();
        busy_cyc_a = 0; done_cnt_a = 0; wr_cnt_a = 0;
        for (int i = 0; i < 16; i++) wcount_a[i] = 0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                exp_a.push_back('{y*3 + x, exp_pix(src_a, 3, 3, x, y)});
    endtask

    task automatic prep_b();
        busy_cyc_b = 0; done_cnt_b = 0; wr_cnt_b = 0;
        for (int i = 0; i < 16; i++) wcount_b[i] = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                exp_b.push_back('{y*4 + x, exp_pix(src_b, 4, 4, x, y)});
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 500) begin @(negedge CLK); n++; end
        if (!done_a) check(tag, 0, 1);
        @(negedge CLK);
    endtask

    task automatic wait_done_b(input string tag);
        int n = 0;
        while (!done_b && n < 1000) begin @(negedge CLK); n++; end
        if (!done_b) check(tag, 0, 1);
        @(negedge CLK);
    endtask

    task automatic check_frame_a(input string tag);
        check({tag, "_busy_cycles"}, busy_cyc_a, frame_cycles(3, 3));
        check({tag, "_done_pulses"}, done_cnt_a, 1);
        check({tag, "_writes"}, wr_cnt_a, 9);
        check({tag, "_queue_left"}, exp_a.size(), 0);
        for (int i = 0; i < 9; i++) check({tag, "_once"}, wcount_a[i], 1);
    endtask

    int win_exp [9];
    int gap_wr;

    initial begin
        nrst_a = 1'b0; nrst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin src_a[i] = 0; src_b[i] = 0; dst_a[i] = -1; dst_b[i] = -1; end
        busy_cyc_a = 0; busy_cyc_b = 0; done_cnt_a = 0; done_cnt_b = 0; wr_cnt_a = 0; wr_cnt_b = 0;

        // Reset
        repeat (3) @(negedge CLK);
        check("rst_busy",    int'(busy_a),    0);
        check("rst_done",    int'(done_a),    0);
        check("rst_rd_en",   int'(rd_en_a),   0);
        check("rst_wr_en",   int'(wr_en_a),   0);
        check("rst_rd_addr", int'(rd_addr_a), 0);
        check("rst_wr_addr", int'(wr_addr_a), 0);
        check("rst_wr_data", int'(wr_data_a), 0);
        check("rst_state",   int'(dut_a.state_q), int'(S_IDLE));
        check("rst_busy_b",  int'(busy_b),    0);
        nrst_a = 1'b1; nrst_b = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_busy_a", int'(busy_a), 0);
        check("idle_busy_b", int'(busy_b), 0);

        // Single 3x3 window
        src_a[0] = 9; src_a[1] = 1; src_a[2] = 8; src_a[3] = 2; src_a[4] = 7;
        src_a[5] = 3; src_a[6] = 6; src_a[7] = 4; src_a[8] = 5;
        prep_a();
        start_a = 1'b1; @(negedge CLK); start_a = 1'b0;
        wait_done_a("single_done_timeout");
        check("single_busy70", busy_cyc_a, 70);
        check("single_center", dst_a[4], 5);
        check_frame_a("single");

        // 4x4 impulse, also used for window order and write latency
        for (int i = 0; i < 16; i++) src_b[i] = 100;
        src_b[5] = 255;
        prep_b();
        start_b = 1'b1; @(negedge CLK); start_b = 1'b0;
        wait_done_b("impulse_done_timeout");
        win_exp[0] = 0; win_exp[1] = 1; win_exp[2] = 2; win_exp[3] = 4; win_exp[4] = 5;
        win_exp[5] = 6; win_exp[6] = 8; win_exp[7] = 9; win_exp[8] = 10;
        for (int k = 0; k < 9; k++) begin
            check("win_rd_en",   int'(rd_log[11 + k]), 1);
            check("win_rd_addr", rd_alog[11 + k], win_exp[k]);
        end
        gap_wr = 0;
        for (int c = 20; c < 20 + CORE_WAIT; c++) gap_wr += int'(wr_log[c]);
        check("wait_no_write", gap_wr, 0);
        check("write_44_en",   int'(wr_log[19 + CORE_WAIT + 1]), 1);
        check("write_44_addr", wr_alog[19 + CORE_WAIT + 1], 5);
        check("impulse_5",  dst_b[5], 100);
        check("impulse_6",  dst_b[6], 100);
        check("impulse_9",  dst_b[9], 100);
        check("impulse_10", dst_b[10], 100);
        for (int i = 0; i < 16; i++) check("impulse_once", wcount_b[i], 1);
        check("impulse_busy", busy_cyc_b, frame_cycles(4, 4));
        check("impulse_queue_left", exp_b.size(), 0);

        // START held high through a whole frame, including the DONE cycle
        for (int i = 0; i < 9; i++) src_a[i] = int'($urandom_range(0, 255));
        prep_a();
        start_a = 1'b1;
        wait_done_a("hold_done_timeout");
        check("hold_idle_after_done", int'(busy_a), 0);
        start_a = 1'b0;
        repeat (10) @(negedge CLK);
        check("hold_stay_idle", int'(busy_a), 0);
        check_frame_a("hold");

        // Abort during WAIT of pixel (1,1)
        for (int i = 0; i < 9; i++) src_a[i] = int'($urandom_range(0, 255));
        prep_a();
        start_a = 1'b1; @(negedge CLK); start_a = 1'b0;
        repeat (29) @(negedge CLK);
        check("abort_in_wait", int'(dut_a.state_q), int'(S_WAIT));
        nrst_a = 1'b0;
        exp_a.delete();
        @(negedge CLK);
        check("abort_busy", int'(busy_a), 0);
        check("abort_wr_en", int'(wr_en_a), 0);
        check("abort_pre_writes", wr_cnt_a, 4);
        @(negedge CLK);
        nrst_a = 1'b1;
        repeat (60) @(negedge CLK);
        check("abort_no_more_writes", wr_cnt_a, 4);
        for (int i = 0; i < 9; i++) src_a[i] = int'($urandom_range(0, 255));
        prep_a();
        start_a = 1'b1; @(negedge CLK); start_a = 1'b0;
        wait_done_a("rerun_done_timeout");
        check_frame_a("rerun");
        for (int i = 0; i < 9; i++) check("rerun_data", dst_a[i], exp_pix(src_a, 3, 3, i % 3, i / 3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/median_frame_sched.md
# median_frame_sched

Frame-level sequencer for the 9-pixel median core. Walks a W×H image held in an external source memory, fetches each 3×3 neighbourhood, streams it into an internal `MEDIAN` instance, and writes the median to an external destination memory. Border pixels are copied unfiltered. It is the top-level controller between frame storage and the median datapath.

## Interface
- `SIZE`, 8, pixel width in bits
- `W`, 16, image width in pixels; must be ≥ 3
- `H`, 16, image height in pixels; must be ≥ 3
- `AW`, `$clog2(W*H)`, address width
- `CLK`  in  1  clock
- `nRST`  in  1  reset, synchronous, active-low
- `START`  in  1  start one frame; sampled only in IDLE
- `BUSY`  out  1  high from the cycle after an accepted START until DONE
- `DONE`  out  1  one-cycle pulse after the last write
- `RD_EN`  out  1  source read strobe
- `RD_ADDR`  out  AW  source address, equal to y*W+x
- `RD_DATA`  in  SIZE  source data, valid exactly 1 cycle after `RD_EN`
- `WR_EN`  out  1  destination write strobe
- `WR_ADDR`  out  AW  destination address, equal to y*W+x
- `WR_DATA`  out  SIZE  destination data

## Operation
**Median core contract**
- `DI` is fed with 9 pixels while `DSI`=1 for exactly 9 consecutive cycles.
- `DO` is valid while `DSO`=1.
- `DSO` first rises in the 42nd consecutive cycle with `DSI`=0.
- The core's `nRST` is tied to `nRST`.

**Pixel order**
- Pixels are processed row-major: y = 0..H-1, x = 0..W-1.
- A pixel is a border pixel when x=0, x=W-1, y=0 or y=H-1.

**FSM states**
- IDLE
  - `START`=1 → go to the first pixel.
  - Each pixel goes to COPY_RD if it is a border pixel, otherwise FETCH.
- COPY_RD: `RD_EN`=1, `RD_ADDR`=(x,y) → COPY_WR.
- COPY_WR: `WR_EN`=1, `WR_DATA`=`RD_DATA`, `WR_ADDR`=(x,y) → next pixel.
- FETCH: 9 cycles with k = 0..8, `RD_EN`=1.
  - `RD_ADDR` = (x-1+k%3, y-1+k/3).
  - `DSI` and `DI` are `RD_EN` and `RD_DATA` delayed by one cycle, so `DSI`=1 on FETCH k=1..8 and the first WAIT cycle.
  - FETCH → WAIT.
- WAIT: hold until `DSO`=1, then capture `DO` into the `WR_DATA` register → WRITE.
  - `DSO` is ignored in every state except WAIT.
  - WAIT lasts 43 cycles.
- WRITE: `WR_EN`=1, `WR_ADDR`=(x,y) → next pixel.
- After the last pixel (W-1, H-1): DONE state, `DONE`=1 for 1 cycle → IDLE.

**Counters**
- x and y wrap at W-1 and H-1 respectively.
- No address arithmetic outside 0..W*H-1.
- Window reads never touch the border condition because only interior pixels fetch.

## Timing
**Reset**
- `BUSY`, `DONE`, `RD_EN`, `WR_EN` = 0.
- `RD_ADDR`, `WR_ADDR`, `WR_DATA` = 0.
- State = IDLE, x = y = k = 0.

**Start and busy**
- START accepted at edge t → `BUSY`=1 from t+1.
- START while BUSY is ignored.
- START and DONE in the same cycle: START is ignored.

**Cycle counts**
- Border pixel: 2 cycles.
- Interior pixel: 9 + 43 + 1 = 53 cycles.
- Frame BUSY cycles = 2·(W·H − (W−2)(H−2)) + 53·(W−2)(H−2) + 1 (the DONE cycle).

**Other rules**
- `RD_EN` and `WR_EN` are never high in the same cycle.
- At most one write per pixel.
- `nRST`=0 mid-frame: the next cycle is the reset state.
  - No further `WR_EN` pulses.
  - The partial frame is discarded.
  - The next START reprocesses from (0,0).

## Structure
**Package `median_sched_pkg`**
- State enum: IDLE, COPY_RD, COPY_WR, FETCH, WAIT, WRITE, DONE.
- `WIN_N` = 9.
- `CORE_WAIT` = 43, used by the bench only.

**Sub-modules**
- One instance: the existing `MEDIAN` core, with `SIZE` passed through.
- Address generation and FSM stay in this module.

## Test plan
- **Reset:** hold `nRST`=0 for 3 cycles → all outputs 0 and state IDLE; `START`=0 afterwards → `BUSY` stays 0.
- **Single window:** W=H=3, source = 9,1,8,2,7,3,6,4,5, `START` pulse.
  - The 8 border addresses are copied verbatim.
  - Address 4 is written with 5.
  - `BUSY` is high for 70 cycles, followed by a single `DONE` pulse.
- **Window order:** W=H=4, pixel (1,1) → `RD_ADDR` sequence 0,1,2,4,5,6,8,9,10 on consecutive cycles; `WR_ADDR`=5 exactly 44 cycles after the last FETCH read.
- **Impulse rejection:** W=H=4, all pixels 100, pixel (1,1)=255 → address 5 written with 100; addresses 6, 9, 10 written with 100; all 16 addresses are written exactly once.
- **Handshake:** `START` held high throughout a W=H=3 frame → exactly one frame is processed; a new frame starts only from IDLE after `DONE`.
- **Abort:** `nRST`=0 during WAIT of pixel (1,1) → no `WR_EN` after reset; a new `START` then produces correct output on all 9 addresses.
